// File: rtl/gift64_round_sched_if.sv
// gift64_round_sched_if: client request/response and round-engine signals of the GIFT-64 scheduler.
// Parameters: NUM_REQ requesters, IDW id width.
// Signals: req_valid/req_ready/req_pt/req_key (client jobs, one-hot grant),
//   dp_load/dp_state_in/dp_key_in/dp_round_en/dp_round_idx/dp_state_out (round engine),
//   rsp_valid/rsp_ready/rsp_data/rsp_id (tagged result), busy (scheduler not idle).
// Modports: master = scheduler side, slave = clients plus engine.
interface gift64_round_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW = 2
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*64-1:0] req_pt;
  logic [NUM_REQ*128-1:0] req_key;
  logic dp_load;
  logic [63:0] dp_state_in;
  logic [127:0] dp_key_in;
  logic dp_round_en;
  logic [5:0] dp_round_idx;
  logic [63:0] dp_state_out;
  logic rsp_valid;
  logic rsp_ready;
  logic [63:0] rsp_data;
  logic [IDW-1:0] rsp_id;
  logic busy;
  modport master (
    input req_valid, req_pt, req_key, dp_state_out, rsp_ready,
    output req_ready, dp_load, dp_state_in, dp_key_in, dp_round_en, dp_round_idx,
    output rsp_valid, rsp_data, rsp_id, busy
  );
  modport slave (
    output req_valid, req_pt, req_key, dp_state_out, rsp_ready,
    input req_ready, dp_load, dp_state_in, dp_key_in, dp_round_en, dp_round_idx,
    input rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/gift64_round_sched.sv
// gift64_round_sched: round-robin scheduler sharing one iterative GIFT-64 round engine among NUM_REQ requesters.
// Ports: clk, rst (asynchronous, active-high), bus (gift64_round_sched_if.master: requests, engine, response).
// Optional GIFT_SCHED_ABORT_EN adds abort (in) / aborted (out): abort in LOAD or RUN drops the job.
module gift64_round_sched #(
  parameter int NUM_REQ = 4,
  parameter int ROUNDS = 28,
  parameter int IDW = 2
) (
  input logic clk,
  input logic rst,
`ifdef GIFT_SCHED_ABORT_EN
  input logic abort,
  output logic aborted,
`endif
  gift64_round_sched_if.master bus
);
  generate
    if (ROUNDS < 1 || ROUNDS > 63 || NUM_REQ < 2 || NUM_REQ > 8 || IDW != $clog2(NUM_REQ)) begin : g_bad_cfg
      $error("gift64_round_sched: illegal parameter combination");
    end
  endgenerate
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t r_state, w_nxt;
  logic [IDW-1:0] r_ptr, r_id, w_gnt_id;
  logic [63:0] r_pt;
  logic [127:0] r_key;
  logic [5:0] r_cnt;
  logic w_found, w_acc, w_abort;
`ifdef GIFT_SCHED_ABORT_EN
  logic r_aborted;
  assign w_abort = abort && (r_state == LOAD || r_state == RUN);
  assign aborted = r_aborted;
`else
  assign w_abort = 1'b0;
`endif
  // first valid requester at or after the rr pointer, wrapping
  always_comb begin
    w_found = 1'b0;
    w_gnt_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && bus.req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_gnt_id = IDW'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end
  assign w_acc = (r_state == IDLE) && w_found;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE: w_nxt = w_acc ? LOAD : IDLE;
      LOAD: w_nxt = RUN;
      RUN: w_nxt = (r_cnt == 6'(ROUNDS - 1)) ? DONE : RUN;
      DONE: w_nxt = bus.rsp_ready ? IDLE : DONE;
      default: w_nxt = IDLE;
    endcase
    if (w_abort) w_nxt = IDLE;
    bus.req_ready = w_acc ? NUM_REQ'(1) << w_gnt_id : '0;
    bus.dp_load = r_state == LOAD;
    bus.dp_round_en = r_state == RUN;
    bus.dp_round_idx = (r_state == RUN) ? r_cnt : '0;
    bus.dp_state_in = r_pt;
    bus.dp_key_in = r_key;
    bus.rsp_valid = r_state == DONE;
    bus.rsp_data = (r_state == DONE) ? bus.dp_state_out : '0;
    bus.rsp_id = (r_state == DONE) ? r_id : '0;
    bus.busy = r_state != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_id <= '0;
      r_pt <= '0;
      r_key <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt <= (r_state == RUN) ? r_cnt + 6'd1 : '0;
      if (w_acc) begin
        r_id <= w_gnt_id;
        r_ptr <= (w_gnt_id == IDW'(NUM_REQ - 1)) ? '0 : w_gnt_id + IDW'(1);
        r_pt <= bus.req_pt[int'(w_gnt_id)*64 +: 64];
        r_key <= bus.req_key[int'(w_gnt_id)*128 +: 128];
      end
    end
  end
`ifdef GIFT_SCHED_ABORT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_aborted <= 1'b0;
    else r_aborted <= w_abort;
  end
`endif
endmodule

// File: tb/tb_gift64_round_sched.sv
// tb_gift64_round_sched: directed scoreboard bench for gift64_round_sched with a toy round engine.
module tb_gift64_round_sched;
  logic clk = 1'b0;
  logic rst;
`ifdef GIFT_SCHED_ABORT_EN
  logic abort;
  logic aborted;
`endif
  int n_vec = 0;
  int n_err = 0;
  logic [65:0] exp_q[$];
  logic [65:0] mon_e;
  logic [63:0] pts [4];
  logic [127:0] keys [4];
  logic [63:0] eng_s;
  logic [127:0] eng_k;
  gift64_round_sched_if #(.NUM_REQ(4), .IDW(2)) bus();
  gift64_round_sched #(.NUM_REQ(4), .ROUNDS(28), .IDW(2)) dut (
    .clk(clk),
    .rst(rst),
`ifdef GIFT_SCHED_ABORT_EN
    .abort(abort),
    .aborted(aborted),
`endif
    .bus(bus.master)
  );
  always #5 clk = ~clk;
  assign bus.req_pt = {pts[3], pts[2], pts[1], pts[0]};
  assign bus.req_key = {keys[3], keys[2], keys[1], keys[0]};
  assign bus.dp_state_out = eng_s;
  function automatic logic [63:0] rnd(input logic [63:0] s, input logic [127:0] k, input logic [5:0] idx);
    return {s[62:0], s[63]} ^ k[63:0] ^ k[127:64] ^ {58'd0, idx};
  endfunction
  function automatic logic [63:0] ref_ct(input logic [63:0] pt, input logic [127:0] k);
    logic [63:0] s;
    s = pt;
    for (int i = 0; i < 28; i++) s = rnd(s, k, 6'(i));
    return s;
  endfunction
  always @(posedge clk) begin
    if (bus.dp_load) begin
      eng_s <= bus.dp_state_in;
      eng_k <= bus.dp_key_in;
    end else if (bus.dp_round_en) eng_s <= rnd(eng_s, eng_k, bus.dp_round_idx);
  end
  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp_unexpected: got id %0d data %0h expected no response", bus.rsp_id, bus.rsp_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp", {bus.rsp_id, bus.rsp_data}, mon_e);
      end
    end
  end
  task automatic push(input int id);
    exp_q.push_back({2'(id), ref_ct(pts[id], keys[id])});
  endtask
  task automatic drain(input string nm);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk(nm, exp_q.size(), 0);
  endtask
  task automatic wait_round(input int idx, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.dp_round_en && bus.dp_round_idx == 6'(idx);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    logic ok;
    int g;
    pts[0] = 64'h0123456789ABCDEF;
    pts[1] = 64'hFEDCBA9876543210;
    pts[2] = 64'h0F0F0F0F00FF00FF;
    pts[3] = 64'hDEADBEEFCAFEF00D;
    keys[0] = 128'h000102030405060708090A0B0C0D0E0F;
    keys[1] = 128'h11112222333344445555666677778888;
    keys[2] = 128'hA5A5A5A55A5A5A5AC3C3C3C33C3C3C3C;
    keys[3] = 128'h0123456789ABCDEFFEDCBA9876543210;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
`ifdef GIFT_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {bus.busy, bus.req_ready, bus.dp_load, bus.dp_round_en, bus.dp_round_idx, bus.rsp_valid, bus.rsp_id}, 0);
    chk("rst_data", {bus.dp_state_in, bus.rsp_data}, 0);
    chk("rst_key", bus.dp_key_in, 0);
    @(posedge clk); #1 rst = 1'b0;
    // single job from requester 0
    bus.req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_grant", bus.req_ready, 4'b0001);
    push(0);
    @(posedge clk); #1 bus.req_valid = '0;
    @(negedge clk);
    chk("t1_load", {bus.dp_load, bus.dp_round_en, bus.req_ready, bus.busy}, {1'b1, 1'b0, 4'b0000, 1'b1});
    chk("t1_state_in", bus.dp_state_in, pts[0]);
    chk("t1_key_in", bus.dp_key_in, keys[0]);
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      chk("t1_round", {bus.dp_load, bus.dp_round_en, bus.dp_round_idx, bus.rsp_valid}, {1'b0, 1'b1, 6'(i), 1'b0});
    end
    @(negedge clk);
    chk("t1_rsp", {bus.rsp_valid, bus.rsp_id, bus.dp_round_en}, {1'b1, 2'd0, 1'b0});
    @(negedge clk);
    chk("t1_idle", {bus.busy, bus.rsp_valid}, 0);
    // reset in the middle of a job from requester 2 (pointer now 1)
    @(posedge clk); #1 bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("t2_grant", bus.req_ready, 4'b0100);
    @(posedge clk); #1 bus.req_valid = '0;
    wait_round(10, ok);
    chk("t2_reach_round10", ok, 1);
    rst = 1'b1;
    #1;
    chk("t2_rst_outputs", {bus.busy, bus.dp_load, bus.dp_round_en, bus.dp_round_idx, bus.rsp_valid, bus.req_ready}, 0);
    chk("t2_rst_data", {bus.dp_state_in, bus.rsp_data}, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_quiet", {bus.busy, bus.rsp_valid}, 0);
    end
    // contention: all four requesting, pointer back at 0
    push(0); push(1); push(2); push(3); push(0);
    @(posedge clk); #1 bus.req_valid = 4'b1111;
    g = 0;
    for (int i = 0; i < 400 && g < 5; i++) begin
      @(negedge clk);
      if (|bus.req_ready) g++;
      @(posedge clk); #1;
    end
    bus.req_valid = '0;
    chk("t3_grants", g, 5);
    drain("t3_drain");
    // backpressure with wrap: pointer at 1, requesters 0 and 3 -> 3 first, then 0
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1001;
    @(negedge clk);
    chk("t4_grant_3", bus.req_ready, 4'b1000);
    push(3);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.rsp_valid;
    end
    chk("t4_reach_done", ok, 1);
    for (int i = 0; i < 10; i++) begin
      chk("t4_stall", {bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req_ready, bus.dp_round_en, bus.dp_load},
          {1'b1, 2'd3, ref_ct(pts[3], keys[3]), 4'b0000, 1'b0, 1'b0});
      @(negedge clk);
    end
    push(0);
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_wrap_grant_0", {bus.busy, bus.req_ready}, {1'b0, 4'b0001});
    @(posedge clk); #1 bus.req_valid = '0;
    drain("t4_drain");
`ifdef GIFT_SCHED_ABORT_EN
    // abort at round 5 of a job from requester 1 (pointer now 1)
    @(posedge clk); #1 bus.req_valid = 4'b0010;
    @(negedge clk);
    chk("t5_grant", bus.req_ready, 4'b0010);
    @(posedge clk); #1 bus.req_valid = '0;
    wait_round(5, ok);
    chk("t5_reach_round5", ok, 1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("t5_aborted", {bus.busy, aborted, bus.rsp_valid, bus.dp_round_en}, {1'b0, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    chk("t5_pulse_end", {aborted, bus.rsp_valid}, 0);
    @(posedge clk); #1 bus.req_valid = 4'b0011;
    @(negedge clk);
    chk("t5_ptr_kept", bus.req_ready, 4'b0001);
    bus.req_valid = '0;
    repeat (40) @(negedge clk);
`endif
    repeat (5) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
